custom_instr_sequencer: RTL
===========================

Name: custom_instr_sequencer

Overview:
- Issues one custom instruction at a time to the FFT, ENCRYPT or DECRYPT accelerator and stalls the core until the selected unit finishes.
- Writes the unit result to the register file; handles illegal codes and unit timeouts.
- Sits between decode (control_t.custom_instr_o, 3-bit custom_instr_t code) and the accelerators and RF write port.
- DATA_MEM (3'b000) is ordinary memory traffic and is ignored by this block.

Parameters:
DATA_W, 19, operand/result width
REG_AW, 4, register address width
TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (1..2^16-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid_i  in  1  decoded instruction valid this cycle
custom_instr_i  in  3  custom_instr_t code
op_a_i  in  DATA_W  rs1 operand
op_b_i  in  DATA_W  rs2 operand
rd_addr_i  in  REG_AW  destination register
stall_o  out  1  hold fetch/decode
busy_o  out  1  state != IDLE
unit_start_o  out  3  one-cycle start; bit0 FFT, bit1 ENCRYPT, bit2 DECRYPT
unit_op_a_o  out  DATA_W  captured operand A
unit_op_b_o  out  DATA_W  captured operand B
unit_done_i  in  3  per-unit done pulse, same bit order
unit_result_i  in  3*DATA_W  per-unit result; unit k at [k*DATA_W +: DATA_W]
rf_wr_en_o  out  1  RF write strobe
rf_wr_addr_o  out  REG_AW  RF write address
rf_wr_data_o  out  DATA_W  RF write data
illegal_o  out  1  one-cycle pulse: unsupported code
timeout_o  out  1  one-cycle pulse: unit timed out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: IDLE. All outputs 0. Captured operands, address, unit select and timer cleared. Reset mid-operation discards the in-flight instruction. A done arriving after reset is ignored.
- Code classes:
  - Legal: FFT 3'b010, ENCRYPT 3'b101, DECRYPT 3'b111.
  - Pass-through: DATA_MEM 3'b000. No action, no stall.
  - Illegal: all other codes. illegal_o pulses on the next cycle, no stall, no start, no RF write.
- "accept" = instr_valid_i && legal code && state in {IDLE, WB}. On accept, register op_a/op_b/rd_addr and the one-hot unit select; next state ISSUE.
- stall_o (combinational) = ISSUE || WAIT || accept.
- States:
  - IDLE: accept -> ISSUE. Otherwise stay in IDLE.
  - ISSUE: unit_start_o = select for exactly one cycle. Timer cleared. unit_done_i ignored. -> WAIT.
  - WAIT: only the selected unit's done bit is observed; other done bits are ignored. Timer increments each cycle.
    - Selected done = 1: latch the selected result slice -> WB.
    - Else, if timer == TIMEOUT_CYCLES-1: -> IDLE, timeout_o = 1 the following cycle, no RF write.
    - Done and timeout limit in the same cycle: done wins.
  - WB: rf_wr_en_o = 1 for one cycle, rf_wr_addr_o = captured rd, rf_wr_data_o = latched result. If rd == 0, rf_wr_en_o = 0 (x0 hardwired). stall_o = 0 unless a new accept occurs. Accept in WB -> ISSUE (back-to-back). Otherwise -> IDLE.
- Operand stability: unit_op_a_o/unit_op_b_o hold their captured values from ISSUE through WB.
- Latency: accept in cycle t → start in t+1; earliest done in t+2; RF write in t+3. In general, the RF write occurs one cycle after the selected done.
- Timer width: clog2(TIMEOUT_CYCLES)+1. The timer never wraps.
- instr_valid_i in ISSUE/WAIT: ignored. The core is stalled, so the instruction is re-presented.

Test Plan:
- FFT, op_a=19'h1_2345, op_b=19'h0_0007, rd=3; FFT done at t+4 with result 19'h7_ABCD -> unit_start_o=3'b001 in t+1, stall_o high t..t+4, in t+5 rf_wr_en=1, addr=3, data=19'h7_ABCD, stall_o=0.
- ENCRYPT accepted; FFT and DECRYPT done pulsed during WAIT, then ENCRYPT done with 19'h0_0F0F -> stray done bits ignored; write 19'h0_0F0F once to the captured rd.
- TIMEOUT_CYCLES=8, DECRYPT never done -> after 8 WAIT cycles, state IDLE, timeout_o single pulse, no RF write, stall_o released.
- Codes 3'b001 then 3'b000 -> illegal_o pulse for the first only; no stall, no start for either.
- Back-to-back ENCRYPT then DECRYPT, second valid in the WB cycle -> first write in WB, unit_start_o=3'b100 the next cycle, no idle gap; rd=0 case -> rf_wr_en_o stays 0.
- rst asserted in WAIT, then a late done -> all outputs 0, IDLE, late done produces no write.

Source files
------------

// File: rtl/custom_instr_sequencer.sv
// custom_instr_sequencer
// Issues one custom instruction (FFT / ENCRYPT / DECRYPT) at a time to its
// accelerator, stalls the core until the selected unit reports done and
// writes the unit result back to the register file. Illegal codes and unit
// timeouts are flagged with one-cycle pulses. DATA_MEM traffic is ignored.
module custom_instr_sequencer #(
    parameter int unsigned DATA_W         = 19,
    parameter int unsigned REG_AW         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid_i,
    input  logic [2:0]            custom_instr_i,
    input  logic [DATA_W-1:0]     op_a_i,
    input  logic [DATA_W-1:0]     op_b_i,
    input  logic [REG_AW-1:0]     rd_addr_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic [2:0]            unit_start_o,
    output logic [DATA_W-1:0]     unit_op_a_o,
    output logic [DATA_W-1:0]     unit_op_b_o,
    input  logic [2:0]            unit_done_i,
    input  logic [3*DATA_W-1:0]   unit_result_i,
    output logic                  rf_wr_en_o,
    output logic [REG_AW-1:0]     rf_wr_addr_o,
    output logic [DATA_W-1:0]     rf_wr_data_o,
    output logic                  illegal_o,
    output logic                  timeout_o
);

    // Decode-side custom instruction codes.
    typedef enum logic [2:0] {
        CI_DATA_MEM = 3'b000,
        CI_FFT      = 3'b010,
        CI_ENCRYPT  = 3'b101,
        CI_DECRYPT  = 3'b111
    } custom_instr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    // Timer counts WAIT cycles and saturates at the limit, so it never wraps.
    localparam int unsigned       TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

    state_t               state_q,   state_d;
    logic [DATA_W-1:0]    op_a_q,    op_a_d;
    logic [DATA_W-1:0]    op_b_q,    op_b_d;
    logic [REG_AW-1:0]    rd_q,      rd_d;
    logic [2:0]           sel_q,     sel_d;
    logic [DATA_W-1:0]    result_q,  result_d;
    logic [TMR_W-1:0]     timer_q,   timer_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;

    logic                 code_legal;
    logic                 code_illegal;
    logic [2:0]           code_sel;
    logic                 can_accept;
    logic                 accept;
    logic                 sel_done;
    logic [DATA_W-1:0]    sel_result;
    logic                 timer_at_limit;

    // Classify the incoming code and map legal codes to a one-hot unit select.
    always_comb begin
        code_legal   = 1'b0;
        code_illegal = 1'b0;
        code_sel     = '0;
        case (custom_instr_i)
            CI_FFT: begin
                code_legal = 1'b1;
                code_sel   = 3'b001;
            end
            CI_ENCRYPT: begin
                code_legal = 1'b1;
                code_sel   = 3'b010;
            end
            CI_DECRYPT: begin
                code_legal = 1'b1;
                code_sel   = 3'b100;
            end
            CI_DATA_MEM: begin
                code_legal = 1'b0;
            end
            default: begin
                code_illegal = 1'b1;
            end
        endcase
    end

    assign can_accept     = (state_q == S_IDLE) || (state_q == S_WB);
    assign accept         = instr_valid_i && code_legal && can_accept;
    assign sel_done       = |(unit_done_i & sel_q);
    assign timer_at_limit = (timer_q == TMR_LAST);

    // Pick the result slice belonging to the selected unit.
    always_comb begin
        sel_result = '0;
        case (sel_q)
            3'b001:  sel_result = unit_result_i[0*DATA_W +: DATA_W];
            3'b010:  sel_result = unit_result_i[1*DATA_W +: DATA_W];
            3'b100:  sel_result = unit_result_i[2*DATA_W +: DATA_W];
            default: sel_result = '0;
        endcase
    end

    // Next-state logic: sequencing, timer, result capture and flag pulses.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_d      = rd_q;
        sel_d     = sel_q;
        result_d  = result_q;
        timer_d   = timer_q;
        illegal_d = instr_valid_i && can_accept && code_illegal;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done has priority over the timeout limit in the same cycle.
                if (sel_done) begin
                    result_d = sel_result;
                    state_d  = S_WB;
                end else if (timer_at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept is only possible from IDLE or WB; in WB it chains straight
        // into the next ISSUE without an idle gap.
        if (accept) begin
            op_a_d  = op_a_i;
            op_b_d  = op_b_i;
            rd_d    = rd_addr_i;
            sel_d   = code_sel;
            state_d = S_ISSUE;
        end
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_q      <= '0;
            sel_q     <= '0;
            result_q  <= '0;
            timer_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_q      <= rd_d;
            sel_q     <= sel_d;
            result_q  <= result_d;
            timer_q   <= timer_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Output decode from the current state and captured values.
    always_comb begin
        stall_o      = (state_q == S_ISSUE) || (state_q == S_WAIT) || accept;
        busy_o       = (state_q != S_IDLE);
        unit_start_o = (state_q == S_ISSUE) ? sel_q : '0;
        unit_op_a_o  = op_a_q;
        unit_op_b_o  = op_b_q;
        rf_wr_en_o   = (state_q == S_WB) && (rd_q != '0);
        rf_wr_addr_o = (state_q == S_WB) ? rd_q : '0;
        rf_wr_data_o = (state_q == S_WB) ? result_q : '0;
        illegal_o    = illegal_q;
        timeout_o    = timeout_q;
    end

endmodule
